seq_pattern_detector: RTL



---
 rtl/patdet_pkg.sv | 24 ++
 rtl/patdet_match_cnt.sv | 35 +++
 rtl/seq_pattern_detector.sv | 126 ++++++++++++
 3 files changed

// File: rtl/patdet_pkg.sv
`default_nettype none
// ============================================================================
// Module   : patdet_pkg
// Brief    : Shared types, limits and length saturation for seq_pattern_detector
// Revision : 1.0 - initial release
// ============================================================================
package patdet_pkg;

    localparam int unsigned MAX_LEN_LIMIT = 32;

    typedef enum logic [1:0] {
        UNCFG = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2
    } patdet_state_e;

    // Lengths programmed above the built-in maximum are clipped, never wrapped.
    function automatic int unsigned patdet_sat_len(input int unsigned len,
                                                   input int unsigned max_len);
        return (len > max_len) ? max_len : len;
    endfunction

endpackage
`default_nettype wire

// File: rtl/patdet_match_cnt.sv
`default_nettype none
// ============================================================================
// Module   : patdet_match_cnt
// Brief    : Saturating match counter with synchronous clear
// Revision : 1.0 - initial release
// ============================================================================
module patdet_match_cnt #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            // A match arriving with the clear is still counted.
            r_cnt <= inc ? CNT_W'(1) : '0;
        end else if (inc && (r_cnt != c_CNT_MAX)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/seq_pattern_detector.sv
`default_nettype none
// ============================================================================
// Module   : seq_pattern_detector
// Brief    : Runtime-programmable serial pattern detector, Mealy match output.
//            Define PATDET_MATCH_CNT_EN to build the saturating match counter.
// Revision : 1.0 - initial release
// ============================================================================
module seq_pattern_detector
    import patdet_pkg::*;
#(
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1),
    parameter int unsigned CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               din,
    input  logic               valid,
    input  logic               cnt_clr,
    output logic               match,
    output logic               armed,
    output logic [CNT_W-1:0]   match_cnt
);

    localparam logic [1:0] c_ST_UNCFG = UNCFG;
    localparam logic [1:0] c_ST_FILL  = FILL;
    localparam logic [1:0] c_ST_RUN   = RUN;

    logic [1:0]         r_state;
    logic [MAX_LEN-1:0] r_pat;
    logic [LEN_W-1:0]   r_len;
    logic               r_ovl;
    logic [MAX_LEN-2:0] r_hist;
    logic [LEN_W-1:0]   r_fill;

    logic [LEN_W-1:0]   w_len_eff;
    logic [LEN_W-1:0]   w_len_m1;
    logic [LEN_W-1:0]   w_fill_inc;
    logic [MAX_LEN-1:0] w_window;
    logic [MAX_LEN-1:0] w_mask;
    logic               w_cmp_eq;
    logic               w_accept;
    logic               w_match;

    assign w_len_eff  = LEN_W'(patdet_sat_len(32'(cfg_len), MAX_LEN));
    assign w_len_m1   = r_len - LEN_W'(1);
    assign w_fill_inc = r_fill + LEN_W'(1);

    // Oldest window bit lands at [len-1], matching the pattern bit order.
    assign w_window = {r_hist, din};

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            w_mask[i] = (LEN_W'(i) < r_len);
        end
    end

    assign w_cmp_eq = (((w_window ^ r_pat) & w_mask) == '0);
    assign w_accept = valid & ~cfg_we & (r_state != c_ST_UNCFG);
    assign w_match  = w_accept & (r_state == c_ST_RUN) & w_cmp_eq;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_UNCFG;
            r_pat   <= '0;
            r_len   <= '0;
            r_ovl   <= 1'b0;
            r_hist  <= '0;
            r_fill  <= '0;
        end else if (cfg_we) begin
            r_pat  <= cfg_pattern;
            r_len  <= w_len_eff;
            r_ovl  <= cfg_overlap;
            r_hist <= '0;
            r_fill <= '0;
            if (w_len_eff == '0) begin
                r_state <= c_ST_UNCFG;
            end else if (w_len_eff == LEN_W'(1)) begin
                r_state <= c_ST_RUN;
            end else begin
                r_state <= c_ST_FILL;
            end
        end else if (w_accept) begin
            if (w_match && !r_ovl && (r_len != LEN_W'(1))) begin
                // Non-overlapping mode: the next match needs a fully fresh window.
                r_hist  <= '0;
                r_fill  <= '0;
                r_state <= c_ST_FILL;
            end else begin
                r_hist <= w_window[MAX_LEN-2:0];
                if (r_fill < w_len_m1) begin
                    r_fill <= w_fill_inc;
                end
                if ((r_state == c_ST_FILL) && (w_fill_inc == w_len_m1)) begin
                    r_state <= c_ST_RUN;
                end
            end
        end
    end

    assign match = w_match;
    assign armed = (r_state == c_ST_RUN);

`ifdef PATDET_MATCH_CNT_EN
    patdet_match_cnt #(
        .CNT_W (CNT_W)
    ) u_match_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (w_match),
        .cnt (match_cnt)
    );
`else
    logic w_unused_cnt_clr;
    assign w_unused_cnt_clr = cnt_clr;
    assign match_cnt        = '0;
`endif

endmodule
`default_nettype wire
